// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM state type and default busy latencies.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_MUL_LAT = 5;
  localparam int MD_DIV_LAT = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_arith.sv
// Combinational datapath for multiply/divide. Produces {hi,lo} and a
// divide-by-zero flag. Signed cases are reduced to unsigned magnitude
// arithmetic so the 0x80000000 / -1 corner falls out naturally.
module muldiv_arith
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic        is_signed_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  // Products on sign- or zero-extended operands; the low 64 bits are exact.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Division through magnitudes; a zero divisor is replaced so the
  // datapath never produces X, the result is discarded in that case anyway.
  always_comb begin
    is_signed_div = (op == MD_DIV);
    neg_a   = is_signed_div & a[31];
    neg_b   = is_signed_div & b[31];
    mag_a   = neg_a ? (32'd0 - a) : a;
    mag_b   = neg_b ? (32'd0 - b) : b;
    divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag   = mag_a / divisor;
    r_mag   = mag_a % divisor;
    quot    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem     = neg_a ? (32'd0 - r_mag) : r_mag;
  end

  // Result select by op; quotient goes to LO, remainder to HI.
  always_comb begin
    result = 64'd0;
    div0   = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV, MD_DIVU: begin
        result = {rem, quot};
        div0   = (b == 32'd0);
      end
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer beside the E stage. Result is computed at
// issue and held in temp registers; HI/LO commit after a fixed busy period.
//
//   state | meaning
//   IDLE  | free, accepts a new issue
//   MUL   | multiply latency running
//   DIV   | divide latency running
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT,
  parameter int DIV_LAT = MD_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        md_in_d_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e   state;
  md_state_e   next_state;
  logic [3:0]  cnt;
  logic [31:0] temp_hi;
  logic [31:0] temp_lo;
  logic        temp_wr;
  logic [63:0] arith_result;
  logic        arith_div0;
  logic        issue;
  logic        finish;

  muldiv_arith u_arith (
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .result (arith_result),
    .div0   (arith_div0)
  );

  assign issue  = (state == IDLE) & start_i;
  assign finish = (state != IDLE) & (cnt == 4'd1);

  // Next-state decode: issues leave IDLE only for mult/div ops.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          case (op_i)
            MD_MULT, MD_MULTU: next_state = MUL;
            MD_DIV, MD_DIVU:   next_state = DIV;
            default:           next_state = IDLE;
          endcase
        end
      end
      MUL, DIV: if (cnt == 4'd1) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // State, busy and done flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= next_state;
      busy_o <= (next_state != IDLE);
      done_o <= finish;
    end
  end

  // Latency counter and temp result capture at issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      temp_wr <= 1'b0;
    end else if (issue) begin
      case (op_i)
        MD_MULT, MD_MULTU: begin
          cnt     <= 4'(MUL_LAT);
          temp_hi <= arith_result[63:32];
          temp_lo <= arith_result[31:0];
          temp_wr <= 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          cnt     <= 4'(DIV_LAT);
          temp_hi <= arith_result[63:32];
          temp_lo <= arith_result[31:0];
          temp_wr <= ~arith_div0;
        end
        default: ;
      endcase
    end else if (state != IDLE) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Architectural HI/LO: direct moves while idle, commit at end of busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_o <= 32'd0;
      lo_o <= 32'd0;
    end else if (issue && op_i == MD_MTHI) begin
      hi_o <= a_i;
    end else if (issue && op_i == MD_MTLO) begin
      lo_o <= a_i;
    end else if (finish && temp_wr) begin
      hi_o <= temp_hi;
      lo_o <= temp_lo;
    end
  end

  // Zero-latency stall toward the hazard controller.
  always_comb begin
    stall_o = md_in_d_i & (start_i | busy_o);
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge (away from the rising edge).
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        md_in_d_i;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total  = 0;
  int passed = 0;

  muldiv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .md_in_d_i (md_in_d_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .stall_o   (stall_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a falling edge; drives one issue cycle and returns at the
  // next falling edge (first cycle after the issue edge).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    chk("no_start_while_busy", {31'd0, busy_o}, 32'd0);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(negedge clk);
    start_i = 1'b0;
    op_i    = 3'd7;
  endtask

  // Counts busy cycles (bounded), then returns in the done cycle.
  task automatic wait_done(input string tag, input int lat, output bit stall_seen);
    int n;
    n = 0;
    stall_seen = 1'b0;
    while (busy_o === 1'b1 && n < 40) begin
      if (stall_o) stall_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(lat));
    chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    bit ss;
    int stall_cnt;
    int k;
    bit done_seen;

    reset = 1'b1; start_i = 1'b0; op_i = 3'd7; a_i = '0; b_i = '0; md_in_d_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);

    // MULT -1 * 2
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult", 5, ss);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("mult_done_pulse", {31'd0, done_o}, 32'd0);

    // MULTU same operands, no D-stage md instruction -> never stalls
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", 5, ss);
    chk("multu_hi", hi_o, 32'h0000_0001);
    chk("multu_lo", lo_o, 32'hFFFF_FFFE);
    chk("multu_no_stall", {31'd0, ss}, 32'd0);
    @(negedge clk);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 10, ss);
    chk("div_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_hi", hi_o, 32'hFFFF_FFFF);
    @(negedge clk);

    // DIVU by zero: full latency, HI/LO untouched, done still pulses
    issue(3'd3, 32'd7, 32'd0);
    wait_done("divu0", 10, ss);
    chk("divu0_lo", lo_o, 32'hFFFF_FFFD);
    chk("divu0_hi", hi_o, 32'hFFFF_FFFF);
    @(negedge clk);

    // Signed overflow corner
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10, ss);
    chk("div_ovf_lo", lo_o, 32'h8000_0000);
    chk("div_ovf_hi", hi_o, 32'h0000_0000);
    @(negedge clk);

    // MTHI / MTLO while idle
    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi_o, 32'h1234_5678);
    chk("mthi_lo", lo_o, 32'h8000_0000);
    chk("mthi_busy", {31'd0, busy_o}, 32'd0);
    chk("mthi_done", {31'd0, done_o}, 32'd0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", lo_o, 32'hCAFE_F00D);
    chk("mtlo_hi", hi_o, 32'h1234_5678);

    // Op 7 does nothing
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    chk("op7_busy", {31'd0, busy_o}, 32'd0);
    chk("op7_hi", hi_o, 32'h1234_5678);
    chk("op7_lo", lo_o, 32'hCAFE_F00D);

    // Stall window: md_in_d_i held from the issue cycle of a MULT
    stall_cnt = 0;
    start_i = 1'b1; op_i = 3'd0; a_i = 32'h0001_0000; b_i = 32'h0001_0000; md_in_d_i = 1'b1;
    #1;
    if (stall_o) stall_cnt++;
    done_seen = 1'b0;
    k = 0;
    while (!done_seen && k < 20) begin
      @(negedge clk);
      start_i = 1'b0; op_i = 3'd7;
      #1;
      if (done_o) done_seen = 1'b1;
      else if (stall_o) stall_cnt++;
      k++;
    end
    chk("stall_cycles", 32'(stall_cnt), 32'd6);
    chk("stall_done_seen", {31'd0, done_seen}, 32'd1);
    chk("stall_in_done", {31'd0, stall_o}, 32'd0);
    chk("stall_mult_hi", hi_o, 32'h0000_0001);
    chk("stall_mult_lo", lo_o, 32'h0000_0000);
    md_in_d_i = 1'b0;

    // Back-to-back issue in the done cycle
    issue(3'd1, 32'd5, 32'd6);
    wait_done("b2b", 5, ss);
    chk("b2b_lo", lo_o, 32'd30);
    chk("b2b_hi", hi_o, 32'd0);
    @(negedge clk);

    // Reset in the 4th busy cycle of a DIV
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_o) done_seen = 1'b1;
    end
    chk("midrst_no_done", {31'd0, done_seen}, 32'd0);

    // Fresh MULT after the aborted divide
    issue(3'd0, 32'd3, 32'd4);
    wait_done("fresh", 5, ss);
    chk("fresh_lo", lo_o, 32'd12);
    chk("fresh_hi", hi_o, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
